// File: rtl/mips_pkg.sv
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared types and constants for the MIPS run-control slice.
//             Provides the run-controller state encoding and the default
//             datapath / program-counter widths.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PC_W       = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4
    } run_state_e;

endpackage

`default_nettype wire

// File: rtl/mips_run_ctrl_if.sv
// ============================================================================
//  Module   : mips_run_ctrl_if
//  Purpose  : Program-source handshake and instruction-memory write port
//             bundle seen by the run controller.
//  Ports    : src_data/src_valid/src_ready  - valid/ready program source
//             imem_we/imem_addr/imem_wdata  - instruction-memory write port
//  Modports : master - the run controller (accepts words, drives imem)
//             slave  - the environment (program source + memory)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips_run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        input  src_data, src_valid,
        output src_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output src_data, src_valid,
        input  src_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mips_halt_detect.sv
// ============================================================================
//  Module   : mips_halt_detect
//  Purpose  : Flags a core halt when the program counter has not changed for
//             HALT_REPEAT consecutive enabled cycles.
//  Ports    : clk, rst_n   - clock, asynchronous active-low reset
//             en           - run window (counting enabled)
//             capture      - load the reference PC ahead of the run window
//             core_pc      - core program counter
//             halted       - combinational: this cycle completes the streak
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_halt_detect
    import mips_pkg::*;
#(
    parameter int HALT_REPEAT = 3
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            en,
    input  wire logic            capture,
    input  wire logic [PC_W-1:0] core_pc,
    output logic                 halted
);

    localparam int                 c_hc_w      = $clog2(HALT_REPEAT + 1);
    localparam logic [c_hc_w-1:0]  c_halt_last = c_hc_w'(HALT_REPEAT - 1);

    logic [PC_W-1:0]   r_pc_prev;
    logic [c_hc_w-1:0] r_hcnt;
    logic              w_same;

    assign w_same = (core_pc == r_pc_prev);

    // The streak completes on the cycle whose comparison would take the
    // counter to HALT_REPEAT, so the controller can leave RUN on that edge.
    assign halted = en && w_same && (r_hcnt >= c_halt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_prev <= '0;
            r_hcnt    <= '0;
        end else begin
            if (en || capture) begin
                r_pc_prev <= core_pc;
            end
            if (!en || !w_same) begin
                r_hcnt <= '0;
            end else if (r_hcnt < c_halt_last) begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips_run_ctrl.sv
// ============================================================================
//  Module   : mips_run_ctrl
//  Purpose  : Run controller for the MIPS core. Holds the core in reset,
//             streams PROG_WORDS program words into instruction memory,
//             releases the core, counts run cycles and ends the run on halt
//             (static PC) or on reaching MAX_CYCLES.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             start                 - begin load-and-run (IDLE/DONE only)
//             bus (master)          - program source + imem write port
//             core_rst_n, core_pc   - core reset / program counter
//             busy, done, timeout   - run status
//             cycle_count           - cycles executed in the current run
//             exp_chksum, prog_chksum, chksum_ok
//                                   - only with MIPS_RUN_CTRL_CHKSUM_EN
//  Options  : MIPS_RUN_CTRL_CHKSUM_EN adds an XOR checksum of loaded words.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_run_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int PROG_WORDS  = 64,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 1000,
    parameter int HALT_REPEAT = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    mips_run_ctrl_if.master       bus,
    output logic                  core_rst_n,
    input  wire logic [PC_W-1:0]  core_pc,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_W-1:0]      cycle_count
`ifdef MIPS_RUN_CTRL_CHKSUM_EN
    ,
    input  wire logic [DATA_W-1:0] exp_chksum,
    output logic [DATA_W-1:0]      prog_chksum,
    output logic                   chksum_ok
`endif
);

    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(PROG_WORDS - 1);
    localparam logic [CNT_W-1:0]  c_max_cyc  = CNT_W'(MAX_CYCLES);

    run_state_e        r_state;
    run_state_e        w_state_next;

    logic              r_src_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [DATA_W-1:0] r_imem_wdata;
    logic              r_core_rst_n;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [ADDR_W-1:0] r_idx;

    logic              w_accept;
    logic              w_last_accept;
    logic              w_halt;
    logic              w_tmo;
    logic              w_start_ok;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign bus.src_ready  = r_src_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign core_rst_n     = r_core_rst_n;
    assign busy           = r_busy;
    assign done           = r_done;
    assign timeout        = r_timeout;
    assign cycle_count    = r_cycle_count;

    assign w_start_ok    = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept      = (r_state == LOAD) && bus.src_valid && r_src_ready;
    assign w_last_accept = w_accept && (r_idx == c_last_idx);

    // Saturating increment; the timeout compare uses the post-increment
    // value so the run stops with cycle_count == MAX_CYCLES exactly.
    assign w_cnt_inc = (r_cycle_count == {CNT_W{1'b1}}) ? r_cycle_count
                                                        : r_cycle_count + 1'b1;
    assign w_tmo     = (w_cnt_inc >= c_max_cyc);

    mips_halt_detect #(
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_detect (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (r_state == RUN),
        .capture (r_state == RELEASE),
        .core_pc (core_pc),
        .halted  (w_halt)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (w_start_ok)           w_state_next = LOAD;
            LOAD:       if (w_last_accept)        w_state_next = RELEASE;
            RELEASE:                              w_state_next = RUN;
            RUN:        if (w_halt || w_tmo)      w_state_next = DONE;
            default:                              w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_ready   <= 1'b0;
            r_imem_we     <= 1'b0;
            r_imem_addr   <= '0;
            r_imem_wdata  <= '0;
            r_core_rst_n  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
            r_idx         <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_cycle_count <= '0;
                        r_idx         <= '0;
                        r_src_ready   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_idx;
                        r_imem_wdata <= bus.src_data;
                        // Index holds at the last word: no wrap-around.
                        if (w_last_accept) begin
                            r_src_ready <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    r_core_rst_n <= 1'b1;
                end
                RUN: begin
                    r_cycle_count <= w_cnt_inc;
                    if (w_halt || w_tmo) begin
                        r_core_rst_n <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        // Halt takes priority when both end the run together.
                        r_timeout    <= !w_halt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MIPS_RUN_CTRL_CHKSUM_EN
    logic [DATA_W-1:0] r_prog_chksum;
    logic              r_chksum_ok;

    assign prog_chksum = r_prog_chksum;
    assign chksum_ok   = r_chksum_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prog_chksum <= '0;
            r_chksum_ok   <= 1'b0;
        end else if (w_start_ok) begin
            r_prog_chksum <= '0;
            r_chksum_ok   <= 1'b0;
        end else if (w_accept) begin
            r_prog_chksum <= r_prog_chksum ^ bus.src_data;
        end else if (r_state == RELEASE) begin
            // Last word is already folded in by the time RELEASE is reached.
            r_chksum_ok <= (r_prog_chksum == exp_chksum);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
// ============================================================================
//  Module   : tb_mips_run_ctrl
//  Purpose  : Self-checking bench for mips_run_ctrl (PROG_WORDS=4,
//             MAX_CYCLES=20, HALT_REPEAT=3). Expected imem writes and run
//             results are queued at stimulus time and popped by a monitor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_run_ctrl;
    import mips_pkg::*;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int PROG_WORDS  = 4;
    localparam int CNT_W       = 16;
    localparam int MAX_CYCLES  = 20;
    localparam int HALT_REPEAT = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic             to;
        logic [CNT_W-1:0] cnt;
    } dn_t;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              core_rst_n;
    logic [PC_W-1:0]   core_pc = '0;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;
`ifdef MIPS_RUN_CTRL_CHKSUM_EN
    logic [DATA_W-1:0] exp_chksum = '0;
    logic [DATA_W-1:0] prog_chksum;
    logic              chksum_ok;
`endif

    mips_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mips_run_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .PROG_WORDS  (PROG_WORDS),
        .CNT_W       (CNT_W),
        .MAX_CYCLES  (MAX_CYCLES),
        .HALT_REPEAT (HALT_REPEAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus.master),
        .core_rst_n  (core_rst_n),
        .core_pc     (core_pc),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
`ifdef MIPS_RUN_CTRL_CHKSUM_EN
        ,
        .exp_chksum  (exp_chksum),
        .prog_chksum (prog_chksum),
        .chksum_ok   (chksum_ok)
`endif
    );

    always #5 clk = ~clk;

    // Core model: PC held at 0 in reset, then steps by 4 each cycle.
    // pc_free=0 stops it at 12 (halt), pc_free=1 never repeats.
    bit pc_free = 1'b0;
    always @(posedge clk) begin
        if (!core_rst_n)                 core_pc <= '0;
        else if (pc_free || core_pc < 12) core_pc <= core_pc + 32'd4;
    end

    int   errors = 0;
    int   checks = 0;
    wr_t  wq[$];
    dn_t  dq[$];
    logic done_d = 1'b0;
    logic [DATA_W-1:0] prog [PROG_WORDS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL imem_write: unexpected write addr=0x%0h data=0x%0h, expected none",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("imem_write", {24'h0, bus.imem_addr, bus.imem_wdata}, {24'h0, e.addr, e.data});
            end
        end
        if (done === 1'b1 && done_d !== 1'b1) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL run_end: unexpected done, expected none");
            end else begin
                dn_t d;
                d = dq.pop_front();
                check("run_timeout", {63'h0, timeout}, {63'h0, d.to});
                check("run_cycle_count", {48'h0, cycle_count}, {48'h0, d.cnt});
                check("run_end_core_rst_n_busy", {62'h0, core_rst_n, busy}, 64'h0);
            end
        end
        done_d <= done;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_busy_done", {62'h0, busy, done}, 64'h2);
    endtask

    task automatic push_done(input logic to, input int cnt);
        dn_t d;
        d.to  = to;
        d.cnt = CNT_W'(cnt);
        dq.push_back(d);
    endtask

    // Feed nwords words; toggle inserts an idle source cycle after each word
    // and pokes start during one stall (must be ignored). A full load also
    // offers an extra word that must not be taken.
    task automatic load(input bit toggle, input int nwords);
        for (int i = 0; i < nwords; i++) begin
            wr_t e;
            bus.src_valid = 1'b1;
            bus.src_data  = prog[i];
            e.addr = ADDR_W'(i);
            e.data = prog[i];
            wq.push_back(e);
            tick();
            if (toggle && i < nwords - 1) begin
                bus.src_valid = 1'b0;
                bus.src_data  = 32'hDEAD_BEEF;
                start         = (i == 1);
                tick();
                start         = 1'b0;
            end
        end
        if (nwords == PROG_WORDS) begin
            bus.src_valid = 1'b1;
            bus.src_data  = 32'hBAD0_BAD0;
            check("src_ready_drop", {63'h0, bus.src_ready}, 64'h0);
            check("core_rst_n_release", {63'h0, core_rst_n}, 64'h0);
            tick();
            check("core_rst_n_run", {63'h0, core_rst_n}, 64'h1);
        end
        bus.src_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done=%b after %0d cycles, expected 1", done, limit);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {58'h0, bus.src_ready, bus.imem_we, core_rst_n, busy, done, timeout}, 64'h0);
        check({tag, "_imem_addr"}, {56'h0, bus.imem_addr}, 64'h0);
        check({tag, "_imem_wdata"}, {32'h0, bus.imem_wdata}, 64'h0);
        check({tag, "_cycle_count"}, {48'h0, cycle_count}, 64'h0);
    endtask

    task automatic set_prog(input logic [31:0] a, b, c, d);
        prog[0] = a;
        prog[1] = b;
        prog[2] = c;
        prog[3] = d;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        #2;
        check_reset_outputs("reset");
        #10;
        rst_n = 1'b1;

        // Constant-valid load then halt at PC 12: 0,4,8,12,12,12,12 -> 7.
        set_prog(32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'h0800_0003);
        pc_free = 1'b0;
        push_done(1'b0, 7);
        do_start();
        load(1'b0, PROG_WORDS);
        wait_done(100);
        tick();
        tick();
        check("count_frozen", {48'h0, cycle_count}, 64'd7);
        check("done_held", {62'h0, done, timeout}, 64'h2);

        // Stalling source; start poked mid-load.
        push_done(1'b0, 7);
        do_start();
        load(1'b1, PROG_WORDS);
        wait_done(100);

        // PC never repeats: timeout at MAX_CYCLES.
        pc_free = 1'b1;
        push_done(1'b1, MAX_CYCLES);
        do_start();
        load(1'b0, PROG_WORDS);
        wait_done(100);
        tick();
        check("timeout_core_rst_n", {62'h0, core_rst_n, timeout}, 64'h1);

        // Asynchronous reset after two words, then a fresh full run.
        pc_free = 1'b0;
        do_start();
        load(1'b0, 2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        #5;
        rst_n = 1'b1;
        set_prog(32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003);
        push_done(1'b0, 7);
        do_start();
        load(1'b0, PROG_WORDS);
        wait_done(100);

`ifdef MIPS_RUN_CTRL_CHKSUM_EN
        set_prog(32'h1, 32'h2, 32'h4, 32'h8);
        exp_chksum = 32'hF;
        push_done(1'b0, 7);
        do_start();
        load(1'b0, PROG_WORDS);
        wait_done(100);
        check("prog_chksum", {32'h0, prog_chksum}, 64'hF);
        check("chksum_ok_match", {63'h0, chksum_ok}, 64'h1);

        exp_chksum = 32'hE;
        push_done(1'b0, 7);
        do_start();
        load(1'b0, PROG_WORDS);
        wait_done(100);
        check("chksum_ok_mismatch", {63'h0, chksum_ok}, 64'h0);
`endif

        tick();
        tick();
        check("writes_outstanding", 64'(wq.size()), 64'h0);
        check("runs_outstanding", 64'(dq.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
